// File: rtl/alu_lockstep_checker.sv
// Lockstep monitor for a reference/DUT ALU pair: tags each issued operation, compares
// both ALU outputs LAT cycles later, keeps statistics and captures the first mismatch.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | not accepting; pipe empty
// ARMED   | accepting (when enabled) and comparing retired tags
// TRIPPED | mismatch threshold reached; alarm sticky until clear/reset
module alu_lockstep_checker #(
  parameter int WIDTH        = 4,
  parameter int OPW          = 2,
  parameter int LAT          = 1,
  parameter int CNT_W        = 16,
  parameter int ALARM_THRESH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [OPW-1:0]     in_op,
  input  logic [WIDTH-1:0]   ref_result,
  input  logic               ref_carry,
  input  logic               ref_zero,
  input  logic [WIDTH-1:0]   dut_result,
  input  logic               dut_carry,
  input  logic               dut_zero,
  input  logic               watch_en,
  input  logic [WIDTH-1:0]   watch_a,
  input  logic [WIDTH-1:0]   watch_b,
  input  logic [OPW-1:0]     watch_op,
  output logic [CNT_W-1:0]   test_count,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [CNT_W-1:0]   watch_count,
  output logic               mm_valid,
  output logic [WIDTH-1:0]   mm_a,
  output logic [WIDTH-1:0]   mm_b,
  output logic [OPW-1:0]     mm_op,
  output logic [WIDTH+1:0]   mm_ref,
  output logic [WIDTH+1:0]   mm_dut,
  output logic               alarm,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_TRIPPED = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);

  state_t state_q, state_nxt;

  logic [LAT-1:0]   pipe_v;
  logic [WIDTH-1:0] pipe_a  [LAT];
  logic [WIDTH-1:0] pipe_b  [LAT];
  logic [OPW-1:0]   pipe_op [LAT];

  logic             accept, tail_v, mismatch, watch_hit;
  logic [WIDTH+1:0] cmp_ref, cmp_dut;
  logic [CNT_W-1:0] tc_nxt, mc_nxt, wc_nxt;

  assign accept    = in_valid & enable & ~clear;
  assign tail_v    = pipe_v[LAT-1];
  assign cmp_ref   = {ref_result, ref_carry, ref_zero};
  assign cmp_dut   = {dut_result, dut_carry, dut_zero};
  assign mismatch  = tail_v & (cmp_ref != cmp_dut);
  assign watch_hit = accept & watch_en & (in_a == watch_a) & (in_b == watch_b) & (in_op == watch_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
    end else if (clear) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= accept;
      for (int i = 1; i < LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Tag payload needs no reset: only the valid bits decide whether it is used.
  always_ff @(posedge clk) begin
    pipe_a[0]  <= in_a;
    pipe_b[0]  <= in_b;
    pipe_op[0] <= in_op;
    for (int i = 1; i < LAT; i++) begin
      pipe_a[i]  <= pipe_a[i-1];
      pipe_b[i]  <= pipe_b[i-1];
      pipe_op[i] <= pipe_op[i-1];
    end
  end

  always_comb begin
    tc_nxt = test_count;
    mc_nxt = mismatch_cnt;
    wc_nxt = watch_count;
    if (tail_v && test_count != CNT_MAX)     tc_nxt = test_count + CNT_ONE;
    if (mismatch && mismatch_cnt != CNT_MAX) mc_nxt = mismatch_cnt + CNT_ONE;
    if (watch_hit && watch_count != CNT_MAX) wc_nxt = watch_count + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_count   <= '0;
      mismatch_cnt <= '0;
      watch_count  <= '0;
      mm_valid     <= 1'b0;
      mm_a         <= '0;
      mm_b         <= '0;
      mm_op        <= '0;
      mm_ref       <= '0;
      mm_dut       <= '0;
    end else if (clear) begin
      test_count   <= '0;
      mismatch_cnt <= '0;
      watch_count  <= '0;
      mm_valid     <= 1'b0;
      mm_a         <= '0;
      mm_b         <= '0;
      mm_op        <= '0;
      mm_ref       <= '0;
      mm_dut       <= '0;
    end else begin
      test_count   <= tc_nxt;
      mismatch_cnt <= mc_nxt;
      watch_count  <= wc_nxt;
      if (mismatch && !mm_valid) begin
        mm_valid <= 1'b1;
        mm_a     <= pipe_a[LAT-1];
        mm_b     <= pipe_b[LAT-1];
        mm_op    <= pipe_op[LAT-1];
        mm_ref   <= cmp_ref;
        mm_dut   <= cmp_dut;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:    if (enable) state_nxt = S_ARMED;
      S_ARMED: begin
        // Tripping uses the post-update count so a saturated counter still trips.
        if (mc_nxt >= THRESH)             state_nxt = S_TRIPPED;
        else if (!enable && pipe_v == '0) state_nxt = S_IDLE;
      end
      S_TRIPPED: state_nxt = S_TRIPPED;
      default:   state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = enable ? S_ARMED : S_IDLE;
  end

  assign state = state_q;
  assign alarm = (state_q == S_TRIPPED);

endmodule
